// File: rtl/mac_job_sequencer_pkg.sv
// Shared definitions for the MAC job sequencer: state encoding, default
// watchdog limit and state-decode helpers used by the top and the watchdog.
package mac_job_sequencer_pkg;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_BASE_ISSUE = 3'd1,
        S_BASE_WAIT  = 3'd2,
        S_FETCH      = 3'd3,
        S_LOAD       = 3'd4,
        S_ISSUE      = 3'd5,
        S_COLLECT    = 3'd6,
        S_DONE       = 3'd7
    } seq_state_t;

    // States that present an operand pair to the MAC
    function automatic logic drives_mac_in(input seq_state_t s);
        return (s == S_BASE_ISSUE) || (s == S_ISSUE);
    endfunction

    // States that accept a MAC response
    function automatic logic accepts_mac_out(input seq_state_t s);
        return (s == S_BASE_WAIT) || (s == S_COLLECT);
    endfunction

endpackage

// File: rtl/mac_seq_watchdog.sv
// Watchdog for MAC handshake waits.
// Counts cycles while run is high; clear (or run low) restarts from zero.
// expire_c is high on the TIMEOUT-th consecutive cycle of a wait.
// Ports: clock, reset (sync, active-high), run, clear, expire_c.
module mac_seq_watchdog
    import mac_job_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_c = run && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Saturating count of cycles spent in the current wait state
    always_comb begin
        cnt_d = cnt_q;
        if (clear || !run) begin
            cnt_d = '0;
        end else if (!expire_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_job_sequencer.sv
// Initiator-side sequencer for the MAC valid/ready handshake.
// Takes a dot-product job (length, x/y base addresses), issues a zero pair to
// sample the MAC accumulator baseline, then fetches and issues each operand
// pair and returns (final accumulator - baseline) mod 2^WIDTH.
// Ports: cmd_* job request, mem_* synchronous-read operand memories,
//        mac_in_* / mac_out_* MAC handshake, res_* job result.
// Optional build macro MAC_TIMEOUT_EN: adds a watchdog that aborts a job with
// res_err=1 when a MAC handshake wait reaches TIMEOUT cycles.
module mac_job_sequencer
    import mac_job_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ADDR_W-1:0] cmd_x_base,
    input  logic [ADDR_W-1:0] cmd_y_base,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_x_addr,
    output logic [ADDR_W-1:0] mem_y_addr,
    input  logic [WIDTH-1:0]  mem_x_data,
    input  logic [WIDTH-1:0]  mem_y_data,
    output logic              mac_in_valid,
    input  logic              mac_in_ready,
    output logic [WIDTH-1:0]  mac_x,
    output logic [WIDTH-1:0]  mac_y,
    input  logic              mac_out_valid,
    output logic              mac_out_ready,
    input  logic [WIDTH-1:0]  mac_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [WIDTH-1:0]  res_data,
    output logic              res_err
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("mac_job_sequencer: TIMEOUT must be nonzero");
    end

    seq_state_t        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] x_base_q, x_base_d;
    logic [ADDR_W-1:0] y_base_q, y_base_d;
    logic [WIDTH-1:0]  baseline_q, baseline_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] mem_x_addr_q, mem_x_addr_d;
    logic [ADDR_W-1:0] mem_y_addr_q, mem_y_addr_d;
    logic              mac_in_valid_q, mac_in_valid_d;
    logic [WIDTH-1:0]  mac_x_q, mac_x_d;
    logic [WIDTH-1:0]  mac_y_q, mac_y_d;
    logic              mac_out_ready_q, mac_out_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [WIDTH-1:0]  res_data_q, res_data_d;

`ifdef MAC_TIMEOUT_EN
    logic res_err_q, res_err_d;
    logic wd_expire_c;

    mac_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .run      (drives_mac_in(state_q) || accepts_mac_out(state_q)),
        .clear    (state_d != state_q),
        .expire_c (wd_expire_c)
    );

    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // Next-state and next-output computation; outputs are decoded from state_d
    // so each registered output lines up with the state it belongs to.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        x_base_d   = x_base_q;
        y_base_d   = y_base_q;
        baseline_d = baseline_q;
        mac_x_d    = mac_x_q;
        mac_y_d    = mac_y_q;
        res_data_d = res_data_q;
`ifdef MAC_TIMEOUT_EN
        res_err_d  = res_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    len_d    = cmd_len;
                    x_base_d = cmd_x_base;
                    y_base_d = cmd_y_base;
                    idx_d    = '0;
                    if (cmd_len == '0) begin
                        res_data_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        mac_x_d = '0;
                        mac_y_d = '0;
                        state_d = S_BASE_ISSUE;
                    end
                end
            end
            S_BASE_ISSUE: begin
                if (mac_in_ready) begin
                    state_d = S_BASE_WAIT;
                end
            end
            S_BASE_WAIT: begin
                if (mac_out_valid) begin
                    baseline_d = mac_result;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                mac_x_d = mem_x_data;
                mac_y_d = mem_y_data;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mac_in_ready) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (mac_out_valid) begin
                    // idx < len here, so the increment cannot wrap
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_d == len_q) begin
                        res_data_d = mac_result - baseline_q;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (res_ready) begin
`ifdef MAC_TIMEOUT_EN
                    res_err_d = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef MAC_TIMEOUT_EN
        // A completed handshake on the expiry cycle wins over the abort
        if (wd_expire_c && (state_d == state_q)) begin
            res_data_d = '0;
            res_err_d  = 1'b1;
            state_d    = S_DONE;
        end
`endif

        cmd_ready_d     = (state_d == S_IDLE);
        mem_en_d        = (state_d == S_FETCH);
        mac_in_valid_d  = drives_mac_in(state_d);
        mac_out_ready_d = accepts_mac_out(state_d);
        res_valid_d     = (state_d == S_DONE);
        mem_x_addr_d    = mem_x_addr_q;
        mem_y_addr_d    = mem_y_addr_q;
        if (state_d == S_FETCH) begin
            mem_x_addr_d = x_base_d + ADDR_W'(idx_d);
            mem_y_addr_d = y_base_d + ADDR_W'(idx_d);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            idx_q           <= '0;
            x_base_q        <= '0;
            y_base_q        <= '0;
            baseline_q      <= '0;
            cmd_ready_q     <= 1'b1;
            mem_en_q        <= 1'b0;
            mem_x_addr_q    <= '0;
            mem_y_addr_q    <= '0;
            mac_in_valid_q  <= 1'b0;
            mac_x_q         <= '0;
            mac_y_q         <= '0;
            mac_out_ready_q <= 1'b0;
            res_valid_q     <= 1'b0;
            res_data_q      <= '0;
`ifdef MAC_TIMEOUT_EN
            res_err_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            idx_q           <= idx_d;
            x_base_q        <= x_base_d;
            y_base_q        <= y_base_d;
            baseline_q      <= baseline_d;
            cmd_ready_q     <= cmd_ready_d;
            mem_en_q        <= mem_en_d;
            mem_x_addr_q    <= mem_x_addr_d;
            mem_y_addr_q    <= mem_y_addr_d;
            mac_in_valid_q  <= mac_in_valid_d;
            mac_x_q         <= mac_x_d;
            mac_y_q         <= mac_y_d;
            mac_out_ready_q <= mac_out_ready_d;
            res_valid_q     <= res_valid_d;
            res_data_q      <= res_data_d;
`ifdef MAC_TIMEOUT_EN
            res_err_q       <= res_err_d;
`endif
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign mem_en        = mem_en_q;
    assign mem_x_addr    = mem_x_addr_q;
    assign mem_y_addr    = mem_y_addr_q;
    assign mac_in_valid  = mac_in_valid_q;
    assign mac_x         = mac_x_q;
    assign mac_y         = mac_y_q;
    assign mac_out_ready = mac_out_ready_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;

endmodule
